// File: rtl/gf180mcu_osu_sc_pkg.sv
// Shared definitions for the AOI21 pipeline bank: parameter limits and the
// per-bit AOI21 function.
package gf180mcu_osu_sc_pkg;

    localparam int WIDTH_MAX  = 64;
    localparam int STAGES_MAX = 8;

    function automatic logic aoi21_f(input logic a0, input logic a1, input logic b);
        return ~((a0 & a1) | b);
    endfunction

endpackage

// File: rtl/aoi21_pipe_stage.sv
// One data+valid register slice of the AOI21 pipeline with load/hold.
// With GF180_AOI21_PIPE_SCAN_EN defined the data bits also shift as a scan chain.
module aoi21_pipe_stage
    import gf180mcu_osu_sc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
`ifdef GF180_AOI21_PIPE_SCAN_EN
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
`endif
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             vld_d, vld_q;

    // next state: scan shift has priority, then load, else hold
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
`ifdef GF180_AOI21_PIPE_SCAN_EN
        if (scan_en) begin
            data_d[0] = scan_in;
            for (int i = 1; i < WIDTH; i++) begin
                data_d[i] = data_q[i-1];
            end
        end else if (load) begin
            data_d = d_in;
            vld_d  = v_in;
        end else begin
            data_d = data_q;
        end
`else
        if (load) begin
            data_d = d_in;
            vld_d  = v_in;
        end else begin
            data_d = data_q;
        end
`endif
    end

    // slice registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= {WIDTH{1'b0}};
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign d_out = data_q;
    assign v_out = vld_q;
`ifdef GF180_AOI21_PIPE_SCAN_EN
    assign scan_out = data_q[WIDTH-1];
`endif

endmodule

// File: rtl/aoi21_pipe_bank.sv
// WIDTH-bit AOI21 bank feeding a STAGES-deep valid/ready pipeline with occupancy count.
// Optional scan chain over the data registers with GF180_AOI21_PIPE_SCAN_EN.
module aoi21_pipe_bank
    import gf180mcu_osu_sc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                        CLK,
    input  logic                        R,
    input  logic [WIDTH-1:0]            A0,
    input  logic [WIDTH-1:0]            A1,
    input  logic [WIDTH-1:0]            B,
    input  logic                        IN_VLD,
    output logic                        IN_RDY,
    output logic [WIDTH-1:0]            Y,
    output logic                        OUT_VLD,
    input  logic                        OUT_RDY,
`ifdef GF180_AOI21_PIPE_SCAN_EN
    input  logic                        SE,
    input  logic                        SI,
    output logic                        SO,
`endif
    output logic [$clog2(STAGES+1)-1:0] CNT
);

    localparam int CW = $clog2(STAGES + 1);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX || STAGES < 1 || STAGES > STAGES_MAX) begin : g_param_bad
        $error("aoi21_pipe_bank: WIDTH or STAGES out of range");
    end

    logic [WIDTH-1:0]  f_s;
    logic [WIDTH-1:0]  d_s [STAGES];
    logic [STAGES-1:0] v_s;
    logic [STAGES-1:0] adv_s;
    logic              se_s;
    logic              in_xfer_s, out_xfer_s;
    logic [CW-1:0]     cnt_d, cnt_q;

`ifdef GF180_AOI21_PIPE_SCAN_EN
    logic scan_c_s [STAGES+1];
    assign se_s        = SE;
    assign scan_c_s[0] = SI;
    assign SO          = scan_c_s[STAGES];
`else
    assign se_s = 1'b0;
`endif

    // combinational AOI21 front end
    always_comb begin
        f_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            f_s[i] = aoi21_f(A0[i], A1[i], B[i]);
        end
    end

    // advance chain from the output back; an empty slot always advances so bubbles collapse
    always_comb begin
        logic carry;
        adv_s = {STAGES{1'b0}};
        carry = ~v_s[STAGES-1] | OUT_RDY;
        adv_s[STAGES-1] = carry;
        for (int k = STAGES - 2; k >= 0; k--) begin
            carry    = ~v_s[k] | carry;
            adv_s[k] = carry;
        end
    end

    assign IN_RDY     = adv_s[0] & ~se_s;
    assign OUT_VLD    = v_s[STAGES-1] & ~se_s;
    assign Y          = d_s[STAGES-1];
    assign in_xfer_s  = IN_VLD & IN_RDY;
    assign out_xfer_s = OUT_VLD & OUT_RDY;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] d_in_s;
        logic             v_in_s;
        if (k == 0) begin : g_first
            assign d_in_s = f_s;
            assign v_in_s = IN_VLD;
        end else begin : g_next
            assign d_in_s = d_s[k-1];
            assign v_in_s = v_s[k-1];
        end
        aoi21_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (CLK),
            .rst      (R),
            .load     (adv_s[k]),
`ifdef GF180_AOI21_PIPE_SCAN_EN
            .scan_en  (SE),
            .scan_in  (scan_c_s[k]),
            .scan_out (scan_c_s[k+1]),
`endif
            .d_in     (d_in_s),
            .v_in     (v_in_s),
            .d_out    (d_s[k]),
            .v_out    (v_s[k])
        );
    end

    // occupancy: +1 on input only, -1 on output only
    always_comb begin
        cnt_d = cnt_q;
        case ({in_xfer_s, out_xfer_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // occupancy register
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CNT = cnt_q;

endmodule

// File: tb/tb_aoi21_pipe_bank.sv
// Scoreboard bench for aoi21_pipe_bank (WIDTH=8, STAGES=2); the scan test
// runs only when GF180_AOI21_PIPE_SCAN_EN is defined.
module tb_aoi21_pipe_bank;

    logic       CLK = 1'b0;
    logic       R;
    logic [7:0] A0, A1, B;
    logic       IN_VLD, IN_RDY, OUT_VLD, OUT_RDY;
    logic [7:0] Y;
    logic [1:0] CNT;
`ifdef GF180_AOI21_PIPE_SCAN_EN
    logic       SE = 1'b0, SI = 1'b0, SO;
`endif

    aoi21_pipe_bank #(.WIDTH(8), .STAGES(2)) dut (
        .CLK(CLK), .R(R), .A0(A0), .A1(A1), .B(B),
        .IN_VLD(IN_VLD), .IN_RDY(IN_RDY), .Y(Y), .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY),
`ifdef GF180_AOI21_PIPE_SCAN_EN
        .SE(SE), .SI(SI), .SO(SO),
`endif
        .CNT(CNT)
    );

    always #5 CLK = ~CLK;

    int         n_chk = 0, n_bad = 0, n_out = 0;
    logic [7:0] sb [$];
    logic       mon_en = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] y_prev = 8'h00;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] b);
        return ~((a0 & a1) | b);
    endfunction

    // scoreboard monitor, sampled on the falling edge before the transfers happen
    always @(negedge CLK) begin
        if (mon_en && !R) begin
            check_eq("cnt", 64'(CNT), 64'(sb.size()));
            if (stall_prev) begin
                check_eq("vld_hold", 64'(OUT_VLD), 64'd1);
                check_eq("y_hold", 64'(Y), 64'(y_prev));
            end
            if (OUT_VLD && OUT_RDY) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 64'd1, 64'd0);
                end else begin
                    check_eq("y", 64'(Y), 64'(sb.pop_front()));
                    n_out++;
                end
            end
            if (IN_VLD && IN_RDY) sb.push_back(model(A0, A1, B));
            stall_prev = OUT_VLD && !OUT_RDY;
            y_prev     = Y;
        end
    end

    task automatic drive(input logic vld, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] b, input logic ordy);
        IN_VLD  = vld;
        A0      = a0;
        A1      = a1;
        B       = b;
        OUT_RDY = ordy;
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_drive(input logic ordy);
        drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), ordy);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        #2;
        R = 1'b1;
        #1;
        check_eq("rst_y", 64'(Y), 64'h00);
        check_eq("rst_vld", 64'(OUT_VLD), 64'd0);
        check_eq("rst_cnt", 64'(CNT), 64'd0);
        sb.delete();
        stall_prev = 1'b0;
        IN_VLD = 1'b0;
        @(posedge CLK);
        #1;
        R = 1'b0;
        check_eq("rdy_after_rst", 64'(IN_RDY), 64'd1);
        mon_en = 1'b1;
    endtask

    initial begin
        int base;
        R = 1'b0; IN_VLD = 1'b0; OUT_RDY = 1'b0;
        A0 = 8'h00; A1 = 8'h00; B = 8'h00;
        #3;
        do_reset();

        // truth check with fixed vector, latency two cycles
        drive(1'b1, 8'hF0, 8'hCC, 8'h0A, 1'b1);
        check_eq("lat_early", 64'(OUT_VLD), 64'd0);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        check_eq("lat_vld", 64'(OUT_VLD), 64'd1);
        check_eq("truth_y", 64'(Y), 64'h35);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

        // streaming: 16 back-to-back vectors
        base = n_out;
        for (int i = 0; i < 16; i++) begin
            check_eq("stream_rdy", 64'(IN_RDY), 64'd1);
            rand_drive(1'b1);
            if (i >= 1) check_eq("stream_cnt", 64'(CNT), 64'd2);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        check_eq("stream_count", 64'(n_out - base), 64'd16);

        // backpressure: fill, hold, then simultaneous in/out
        drive(1'b1, 8'h12, 8'h34, 8'h56, 1'b0);
        drive(1'b1, 8'hFF, 8'h0F, 8'h00, 1'b0);
        drive(1'b1, 8'hAA, 8'h55, 8'h01, 1'b0);
        check_eq("bp_cnt", 64'(CNT), 64'd2);
        check_eq("bp_rdy", 64'(IN_RDY), 64'd0);
        check_eq("bp_y", 64'(Y), 64'(model(8'h12, 8'h34, 8'h56)));
        drive(1'b1, 8'hAA, 8'h55, 8'h01, 1'b0);
        check_eq("bp_y_stable", 64'(Y), 64'(model(8'h12, 8'h34, 8'h56)));
        drive(1'b1, 8'hAA, 8'h55, 8'h01, 1'b1);
        check_eq("bp_swap_cnt", 64'(CNT), 64'd2);
        check_eq("bp_swap_y", 64'(Y), 64'(model(8'hFF, 8'h0F, 8'h00)));
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

        // bubble collapse: second entry accepted behind a stalled head
        drive(1'b1, 8'h81, 8'h7E, 8'h10, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        check_eq("bub_vld", 64'(OUT_VLD), 64'd1);
        check_eq("bub_rdy", 64'(IN_RDY), 64'd1);
        check_eq("bub_cnt1", 64'(CNT), 64'd1);
        drive(1'b1, 8'h3C, 8'hC3, 8'h00, 1'b0);
        check_eq("bub_cnt2", 64'(CNT), 64'd2);
        check_eq("bub_y", 64'(Y), 64'(model(8'h81, 8'h7E, 8'h10)));
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

        // mid-operation reset discards in-flight data
        rand_drive(1'b1);
        rand_drive(1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
            check_eq("post_rst_vld", 64'(OUT_VLD), 64'd0);
        end

`ifdef GF180_AOI21_PIPE_SCAN_EN
        begin
            logic [15:0] pat, got;
            pat = 16'hA5C3;
            got = 16'h0000;
            drive(1'b1, 8'h01, 8'h02, 8'h03, 1'b0);
            drive(1'b1, 8'h04, 8'h05, 8'h06, 1'b0);
            IN_VLD = 1'b0;
            mon_en = 1'b0;
            SE = 1'b1;
            #1;
            check_eq("scan_outvld", 64'(OUT_VLD), 64'd0);
            check_eq("scan_inrdy", 64'(IN_RDY), 64'd0);
            for (int i = 0; i < 16; i++) begin
                SI = pat[15-i];
                @(posedge CLK);
                #1;
            end
            for (int i = 0; i < 16; i++) begin
                got[15-i] = SO;
                SI = 1'b0;
                @(posedge CLK);
                #1;
            end
            check_eq("scan_so", 64'(got), 64'(pat));
            check_eq("scan_cnt", 64'(CNT), 64'd2);
            SE = 1'b0;
            #1;
            check_eq("scan_vld_back", 64'(OUT_VLD), 64'd1);
            do_reset();
        end
`endif

        // final drain of anything left in flight
        for (int i = 0; i < 10 && sb.size() > 0; i++) drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        check_eq("drain", 64'(sb.size()), 64'd0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
